// File: rtl/fake_netlist_sched_pkg.sv
// Shared types and default sizing for the netlist evaluation scheduler.
package fake_netlist_sched_pkg;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_IN_W       = 14;
  localparam int DEF_SETTLE_CYC = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/fake_netlist_eval_sched_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr wins.
module rr_arbiter import fake_netlist_sched_pkg::*; #(
  parameter int N = DEF_NUM_REQ,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  // Walk the requesters starting at ptr and latch onto the first active one
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        grant_o[cand] = 1'b1;
        grant_idx_o   = cand;
        any_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fake_netlist_eval_sched.sv
// Time-shares one external netlist among several requesters: grant, drive
// the netlist inputs, wait a fixed settle time, capture the output, respond.
module fake_netlist_eval_sched import fake_netlist_sched_pkg::*; #(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int IN_W       = DEF_IN_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*IN_W-1:0] req_vec,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [IN_W-1:0]         dut_in,
  input  logic                    dut_out,
  output logic                    resp_valid,
  output logic [IDW-1:0]          resp_id,
  output logic                    resp_data,
  input  logic                    resp_ready,
  output logic                    busy
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYC);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IN_W-1:0] dut_in_q, dut_in_d;
  logic [IDW-1:0] resp_id_q, resp_id_d;
  logic           resp_data_q, resp_data_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               arb_any;
  logic [IN_W-1:0]    vec_slice [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign vec_slice[g] = req_vec[g*IN_W +: IN_W];
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  // Next-state and grant logic; req_ready is only ever offered from IDLE
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    dut_in_d    = dut_in_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    req_ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_any && rst_n) begin
          req_ready = arb_grant;
          dut_in_d  = vec_slice[arb_idx];
          resp_id_d = arb_idx;
          cnt_d     = SETTLE_LOAD;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CW'(1)) begin
          resp_data_d = dut_out;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          ptr_d   = (resp_id_q == IDW'(NUM_REQ - 1)) ? '0 : resp_id_q + IDW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any evaluation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      dut_in_q    <= '0;
      resp_id_q   <= '0;
      resp_data_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      dut_in_q    <= dut_in_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign dut_in     = dut_in_q;
  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fake_netlist_eval_sched.sv
// Self-checking bench for fake_netlist_eval_sched with a stand-in netlist.
module tb_fake_netlist_eval_sched;

  parameter int SETTLE_CYC = 2;
  localparam int S = SETTLE_CYC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [55:0] req_vec;
  logic [3:0]  req_ready;
  logic [13:0] dut_in;
  logic        dut_out;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic        resp_data;
  logic        resp_ready;
  logic        busy;

  logic [13:0] vecs [4];

  typedef struct {
    logic [1:0]  id;
    logic        data;
    logic [13:0] vec;
  } exp_t;
  exp_t sbq[$];

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int tbPtr = 0;

  // Stand-in for the external netlist: a fixed mix of XOR, AND and OR terms
  function automatic logic netModel(input logic [13:0] v);
    return (^(v & 14'h2D5B)) ^ (v[13] & v[2]) ^ (v[7] | (v[4] & v[9]));
  endfunction

  // Round-robin reference: first active requester at or after the pointer
  function automatic int predictGrant(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  assign req_vec = {vecs[3], vecs[2], vecs[1], vecs[0]};
  assign dut_out = netModel(dut_in);

  fake_netlist_eval_sched #(.NUM_REQ(4), .IN_W(14), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_vec    (req_vec),
    .req_ready  (req_ready),
    .dut_in     (dut_in),
    .dut_out    (dut_out),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  // Free-running clock and a cycle counter used for latency measurements
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Background guard: never more than one ready bit, and none while busy
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      compared++;
      if (!$onehot0(req_ready) || (busy && req_ready != 4'b0)) begin
        mismatched++;
        $display("[TB] FAIL ready_guard: req_ready=%b busy=%b, required one-hot-or-zero and zero when busy",
                 req_ready, busy);
      end
    end
  end

  // Drive new inputs just after a rising edge so the whole cycle sees them
  task automatic applyStimulus(input logic [3:0] rv, input logic rr);
    @(posedge clk);
    #1;
    req_valid  = rv;
    resp_ready = rr;
  endtask

  // Wait (bounded) for the next grant strobe, sampled on falling edges
  task automatic waitGrant(output bit ok, output logic [3:0] g, output int c);
    ok = 1'b0; g = '0; c = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        ok = 1'b1; g = req_ready; c = cyc;
        return;
      end
    end
  endtask

  // Wait (bounded) for resp_valid, sampled on falling edges
  task automatic waitResp(output bit ok, output int c);
    ok = 1'b0; c = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        ok = 1'b1; c = cyc;
        return;
      end
    end
  endtask

  // Pulse reset and resynchronise the bench's view of the pointer
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tbPtr = 0;
    sbq.delete();
  endtask

  // Outputs must all be zero while reset is held, even with requests pending
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) vecs[i] = 14'($urandom);
    repeat (2) @(negedge clk);
    compared++;
    if (req_ready !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_req_ready: got %b want 0000", req_ready); end
    compared++;
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    compared++;
    if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_valid: got %b want 0", resp_valid); end
    compared++;
    if (dut_in !== 14'h0) begin mismatched++; $display("[TB] FAIL reset_dut_in: got %h want 0000", dut_in); end
    compared++;
    if ({resp_id, resp_data} !== 3'b0) begin mismatched++; $display("[TB] FAIL reset_resp: got id=%0d data=%b want 0/0", resp_id, resp_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1; req_valid = '0; tbPtr = 0;
  endtask

  // Single request from requester 0 with the reference vector 0x1A5
  task automatic test_single();
    bit ok; logic [3:0] g; int gc, rc, sc; exp_t e;
    vecs[0] = 14'h1A5;
    e.id = 2'd0; e.vec = 14'h1A5; e.data = netModel(14'h1A5);
    sbq.push_back(e);
    applyStimulus(4'b0001, 1'b1);
    sc = cyc;
    waitGrant(ok, g, gc);
    compared++;
    if (!ok || g !== 4'b0001 || gc != sc) begin
      mismatched++; $display("[TB] FAIL single_grant: got %b in cycle %0d want 0001 in cycle %0d", g, gc, sc);
    end
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    compared++;
    if (dut_in !== 14'h1A5) begin mismatched++; $display("[TB] FAIL single_dut_in: got %h want 01a5", dut_in); end
    compared++;
    if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL single_busy: got %b want 1", busy); end
    waitResp(ok, rc);
    compared++;
    if (!ok) begin
      mismatched++; $display("[TB] FAIL single_resp_timeout: got no resp_valid want resp_valid");
    end else begin
      e = sbq.pop_front();
      if (rc - gc != S + 1 || resp_id !== e.id || resp_data !== e.data) begin
        mismatched++;
        $display("[TB] FAIL single_resp: got lat=%0d id=%0d data=%b want lat=%0d id=%0d data=%b",
                 rc - gc, resp_id, resp_data, S + 1, e.id, e.data);
      end
    end
    tbPtr = 1;
    @(negedge clk);
    compared++;
    if ({busy, resp_valid} !== 2'b00) begin mismatched++; $display("[TB] FAIL single_idle: got busy=%b valid=%b want 0/0", busy, resp_valid); end
  endtask

  // All four requesting continuously: strict rotation 0,1,2,3,0 at fixed spacing
  task automatic test_back_to_back();
    bit ok; logic [3:0] g, eg; int gc, rc, prevG; exp_t e;
    doReset();
    for (int i = 0; i < 4; i++) vecs[i] = 14'($urandom);
    applyStimulus(4'b1111, 1'b1);
    prevG = 0;
    for (int k = 0; k < 5; k++) begin
      eg = 4'b0001 << (k % 4);
      e.id = 2'(k % 4); e.vec = vecs[k % 4]; e.data = netModel(vecs[k % 4]);
      sbq.push_back(e);
      waitGrant(ok, g, gc);
      compared++;
      if (!ok || g !== eg) begin mismatched++; $display("[TB] FAIL rotate_grant%0d: got %b want %b", k, g, eg); end
      if (k > 0) begin
        compared++;
        if (gc - prevG != S + 2) begin mismatched++; $display("[TB] FAIL rotate_spacing%0d: got %0d want %0d", k, gc - prevG, S + 2); end
      end
      prevG = gc;
      waitResp(ok, rc);
      compared++;
      if (!ok) begin
        mismatched++; $display("[TB] FAIL rotate_resp_timeout%0d: got none want response", k);
      end else begin
        e = sbq.pop_front();
        if (rc - gc != S + 1 || resp_id !== e.id || resp_data !== e.data) begin
          mismatched++;
          $display("[TB] FAIL rotate_resp%0d: got lat=%0d id=%0d data=%b want lat=%0d id=%0d data=%b",
                   k, rc - gc, resp_id, resp_data, S + 1, e.id, e.data);
        end
      end
    end
    req_valid = 4'b0000;
    tbPtr = 1;
    @(negedge clk);
  endtask

  // Consumer stalls for ten cycles: response must hold and nothing new granted
  task automatic test_hold();
    bit ok; logic [3:0] g; int gc, rc; exp_t e;
    vecs[2] = 14'($urandom);
    e.id = 2'd2; e.vec = vecs[2]; e.data = netModel(vecs[2]);
    applyStimulus(4'b0100, 1'b0);
    waitGrant(ok, g, gc);
    compared++;
    if (!ok || g !== 4'b0100) begin mismatched++; $display("[TB] FAIL hold_grant: got %b want 0100", g); end
    applyStimulus(4'b0000, 1'b0);
    waitResp(ok, rc);
    compared++;
    if (!ok || resp_id !== e.id || resp_data !== e.data) begin
      mismatched++; $display("[TB] FAIL hold_resp: got id=%0d data=%b want id=%0d data=%b", resp_id, resp_data, e.id, e.data);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      compared++;
      if ({resp_valid, busy, req_ready, resp_id, resp_data} !== {1'b1, 1'b1, 4'b0000, e.id, e.data}) begin
        mismatched++;
        $display("[TB] FAIL hold_stable%0d: got valid=%b busy=%b ready=%b id=%0d data=%b want 1/1/0000/%0d/%b",
                 i, resp_valid, busy, req_ready, resp_id, resp_data, e.id, e.data);
      end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    compared++;
    if ({busy, resp_valid} !== 2'b00) begin mismatched++; $display("[TB] FAIL hold_release: got busy=%b valid=%b want 0/0", busy, resp_valid); end
    tbPtr = 3;
  endtask

  // Reset during SETTLE of requester 2: no response, pointer back to 0
  task automatic test_reset_midflight();
    bit ok; logic [3:0] g; int gc, rc, relC; exp_t e;
    vecs[2] = 14'($urandom);
    applyStimulus(4'b0100, 1'b1);
    waitGrant(ok, g, gc);
    compared++;
    if (!ok || g !== 4'b0100) begin mismatched++; $display("[TB] FAIL midrst_grant: got %b want 0100", g); end
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    compared++;
    if ({busy, resp_valid, req_ready, dut_in, resp_id} !== 22'b0) begin
      mismatched++; $display("[TB] FAIL midrst_async: got busy=%b valid=%b dut_in=%h id=%0d want all zero", busy, resp_valid, dut_in, resp_id);
    end
    tbPtr = 0;
    sbq.delete();
    vecs[1] = 14'($urandom);
    e.id = 2'd1; e.vec = vecs[1]; e.data = netModel(vecs[1]);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req_valid = 4'b1010;
    relC = cyc;
    waitGrant(ok, g, gc);
    compared++;
    if (!ok || g !== 4'b0010 || gc != relC) begin
      mismatched++; $display("[TB] FAIL midrst_regrant: got %b in cycle %0d want 0010 in cycle %0d", g, gc, relC);
    end
    applyStimulus(4'b0000, 1'b1);
    waitResp(ok, rc);
    compared++;
    if (!ok) begin
      mismatched++; $display("[TB] FAIL midrst_resp_timeout: got none want response");
    end else begin
      e = sbq.pop_front();
      if (resp_id !== e.id || resp_data !== e.data) begin
        mismatched++; $display("[TB] FAIL midrst_resp: got id=%0d data=%b want id=%0d data=%b", resp_id, resp_data, e.id, e.data);
      end
    end
    tbPtr = 2;
    @(negedge clk);
  endtask

  // Only requester 3 active: it wins five slots in a row with fresh vectors
  task automatic test_single_requester();
    bit ok; logic [3:0] g; int gc, rc, prevG; logic [13:0] cur; exp_t e;
    vecs[3] = 14'($urandom);
    applyStimulus(4'b1000, 1'b1);
    prevG = 0;
    for (int i = 0; i < 5; i++) begin
      cur = vecs[3];
      e.id = 2'd3; e.vec = cur; e.data = netModel(cur);
      sbq.push_back(e);
      waitGrant(ok, g, gc);
      compared++;
      if (!ok || g !== 4'b1000) begin mismatched++; $display("[TB] FAIL solo_grant%0d: got %b want 1000", i, g); end
      if (i > 0) begin
        compared++;
        if (gc - prevG != S + 2) begin mismatched++; $display("[TB] FAIL solo_spacing%0d: got %0d want %0d", i, gc - prevG, S + 2); end
      end
      prevG = gc;
      @(posedge clk);
      #1;
      vecs[3] = 14'($urandom);
      @(negedge clk);
      compared++;
      if (dut_in !== cur) begin mismatched++; $display("[TB] FAIL solo_dut_in%0d: got %h want %h", i, dut_in, cur); end
      waitResp(ok, rc);
      compared++;
      if (!ok) begin
        mismatched++; $display("[TB] FAIL solo_resp_timeout%0d: got none want response", i);
      end else begin
        e = sbq.pop_front();
        if (rc - gc != S + 1 || resp_id !== e.id || resp_data !== e.data) begin
          mismatched++;
          $display("[TB] FAIL solo_resp%0d: got lat=%0d id=%0d data=%b want lat=%0d id=%0d data=%b",
                   i, rc - gc, resp_id, resp_data, S + 1, e.id, e.data);
        end
      end
    end
    req_valid = 4'b0000;
    tbPtr = 0;
    @(negedge clk);
  endtask

  // Random request patterns, vectors and consumer stalls against the models
  task automatic test_random();
    bit ok; logic [3:0] g, rv, eg; int gc, rc, eI, stall; exp_t e;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < 4; i++) vecs[i] = 14'($urandom);
      rv = 4'($urandom_range(1, 15));
      stall = $urandom_range(0, 3);
      eI = predictGrant(rv, tbPtr);
      eg = 4'b0001 << eI;
      e.id = 2'(eI); e.vec = vecs[eI]; e.data = netModel(vecs[eI]);
      sbq.push_back(e);
      applyStimulus(rv, stall == 0);
      waitGrant(ok, g, gc);
      compared++;
      if (!ok || g !== eg) begin mismatched++; $display("[TB] FAIL rand_grant%0d: got %b want %b (valid %b)", it, g, eg, rv); end
      applyStimulus(4'b0000, stall == 0);
      waitResp(ok, rc);
      compared++;
      if (!ok) begin
        mismatched++; $display("[TB] FAIL rand_resp_timeout%0d: got none want response", it);
      end else begin
        e = sbq.pop_front();
        if (rc - gc != S + 1 || resp_id !== e.id || resp_data !== e.data) begin
          mismatched++;
          $display("[TB] FAIL rand_resp%0d: got lat=%0d id=%0d data=%b want lat=%0d id=%0d data=%b",
                   it, rc - gc, resp_id, resp_data, S + 1, e.id, e.data);
        end
      end
      for (int k = 0; k < stall; k++) begin
        @(negedge clk);
        compared++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, e.id, e.data}) begin
          mismatched++; $display("[TB] FAIL rand_stall%0d: got valid=%b id=%0d data=%b want 1/%0d/%b", it, resp_valid, resp_id, resp_data, e.id, e.data);
        end
      end
      resp_ready = 1'b1;
      @(negedge clk);
      compared++;
      if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rand_drain%0d: got valid=%b want 0", it, resp_valid); end
      tbPtr = (eI + 1) % 4;
    end
  endtask

  // Hard stop in case something above never returns
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Scenario sequence and final report
  initial begin
    rst_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) vecs[i] = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_reset_midflight();
    test_single_requester();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
